// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared opcodes, flag indices and FSM encodings for seq_alu
//
// Purpose: common constants for the sequential accumulator ALU and its
//          shift-add multiplier core.
// Ports:   none (package)

package alu_pkg;

  // Opcode encodings (3-bit op field)
  localparam logic [2:0] OP_ADD   = 3'b000;
  localparam logic [2:0] OP_SUB   = 3'b001;
  localparam logic [2:0] OP_XOR   = 3'b010;
  localparam logic [2:0] OP_AND   = 3'b011;
  localparam logic [2:0] OP_OR    = 3'b100;
  localparam logic [2:0] OP_MUL   = 3'b101;
  localparam logic [2:0] OP_PASSB = 3'b110;
  localparam logic [2:0] OP_ILL   = 3'b111;

  // Bit positions inside the 4-bit {Z,N,C,V} flags vector
  localparam int FLG_Z = 3;
  localparam int FLG_N = 2;
  localparam int FLG_C = 1;
  localparam int FLG_V = 0;

  // Controller FSM state encodings
  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_MUL  = 1'b1;

endpackage

// File: rtl/seq_mul.sv
// rtl/seq_mul.sv - WIDTH-bit unsigned shift-add multiplier core
//
// Purpose: computes a*b over 2*WIDTH bits, one shift-add iteration per cycle.
// Ports:
//   clk   in   1          rising-edge clock
//   rst   in   1          synchronous reset, active-high; aborts a run
//   load  in   1          capture a/b and start a new product
//   a     in   WIDTH      multiplicand
//   b     in   WIDTH      multiplier
//   busy  out  1          iterations remaining
//   done  out  1          the iteration on the coming edge is the last one
//   prod  out  2*WIDTH    product after the iteration on the coming edge;
//                         equals a*b while done=1

module seq_mul
  import alu_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] prod
);

  localparam int CW = $clog2(WIDTH + 1);

  logic [CW-1:0]      cnt;
  logic [WIDTH-1:0]   mcand;
  // Upper half accumulates partial sums; lower half starts as the multiplier
  // and is shifted out one bit per iteration.
  logic [2*WIDTH-1:0] work;
  logic [WIDTH:0]     partial;

  always_comb begin
    partial = {1'b0, work[2*WIDTH-1:WIDTH]} + (work[0] ? {1'b0, mcand} : '0);
    prod    = {partial, work[WIDTH-1:1]};
    busy    = (cnt != '0);
    done    = (cnt == CW'(1));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt   <= '0;
      mcand <= '0;
      work  <= '0;
    end else if (load) begin
      cnt   <= CW'(WIDTH);
      mcand <= a;
      work  <= {{WIDTH{1'b0}}, b};
    end else if (busy) begin
      work  <= prod;
      cnt   <= cnt - CW'(1);
    end
  end

endmodule

// File: rtl/seq_alu.sv
// rtl/seq_alu.sv - WIDTH-bit accumulator ALU with multi-cycle shift-add MUL
//
// Purpose: single-cycle ADD/SUB/XOR/AND/OR/PASSB and a WIDTH-cycle unsigned
//          MUL, with start/busy/done handshake, registered {Z,N,C,V} flags
//          and accumulator chaining through use_acc.
// Ports:
//   clk      in   1       rising-edge clock
//   rst      in   1       synchronous reset, active-high
//   start    in   1       request; sampled only when busy=0
//   op       in   3       opcode, sampled with start
//   use_acc  in   1       1: operand A = acc_lo; 0: operand A = a
//   a        in   WIDTH   operand A
//   b        in   WIDTH   operand B
//   busy     out  1       MUL in progress
//   done     out  1       one-cycle pulse: result/flags updated
//   err      out  1       illegal opcode, valid with done
//   acc_lo   out  WIDTH   result (low half of product for MUL)
//   acc_hi   out  WIDTH   high half of product; 0 after non-MUL ops
//   flags    out  4       {Z,N,C,V}

module seq_alu
  import alu_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter bit MUL_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic             use_acc,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [WIDTH-1:0] acc_lo,
  output logic [WIDTH-1:0] acc_hi,
  output logic [3:0]       flags
);

  logic [0:0]         state;
  logic               accept;
  logic               is_mul;
  logic               is_ill;
  logic [WIDTH-1:0]   opa;

  logic [WIDTH:0]     sum;
  logic [WIDTH-1:0]   res;
  logic               res_c;
  logic               res_v;
  logic [3:0]         sc_flags;

  logic               mul_load;
  logic               mul_busy;
  logic               mul_done;
  logic [2*WIDTH-1:0] mul_prod;
  logic [3:0]         mul_flags;

  // Operand A is taken from the registered accumulator, so a chained op sees
  // the result of the op accepted on the previous edge.
  assign opa    = use_acc ? acc_lo : a;
  assign accept = start && (state == ST_IDLE);
  assign is_mul = (op == OP_MUL) && MUL_EN;
  assign is_ill = (op == OP_ILL) || ((op == OP_MUL) && !MUL_EN);

  assign mul_load = accept && is_mul;

  seq_mul #(
    .WIDTH (WIDTH)
  ) u_mul (
    .clk  (clk),
    .rst  (rst),
    .load (mul_load),
    .a    (opa),
    .b    (b),
    .busy (mul_busy),
    .done (mul_done),
    .prod (mul_prod)
  );

  // The core is busy exactly from the accept edge to the completion edge,
  // which is the window the controller must see as busy.
  assign busy = mul_busy;

  // Single-cycle datapath
  always_comb begin
    sum   = '0;
    res   = '0;
    res_c = 1'b0;
    res_v = 1'b0;
    case (op)
      OP_ADD: begin
        sum   = {1'b0, opa} + {1'b0, b};
        res   = sum[WIDTH-1:0];
        res_c = sum[WIDTH];
        res_v = (opa[WIDTH-1] == b[WIDTH-1]) && (res[WIDTH-1] != opa[WIDTH-1]);
      end
      OP_SUB: begin
        // C=1 means no borrow
        sum   = {1'b0, opa} + {1'b0, ~b} + (WIDTH+1)'(1);
        res   = sum[WIDTH-1:0];
        res_c = sum[WIDTH];
        res_v = (opa[WIDTH-1] != b[WIDTH-1]) && (res[WIDTH-1] != opa[WIDTH-1]);
      end
      OP_XOR:   res = opa ^ b;
      OP_AND:   res = opa & b;
      OP_OR:    res = opa | b;
      OP_PASSB: res = b;
      default:  res = '0;
    endcase
  end

  always_comb begin
    sc_flags        = '0;
    sc_flags[FLG_Z] = (res == '0);
    sc_flags[FLG_N] = res[WIDTH-1];
    sc_flags[FLG_C] = res_c;
    sc_flags[FLG_V] = res_v;

    mul_flags        = '0;
    mul_flags[FLG_Z] = (mul_prod == '0);
    mul_flags[FLG_N] = mul_prod[2*WIDTH-1];
    mul_flags[FLG_C] = (mul_prod[2*WIDTH-1:WIDTH] != '0);
    mul_flags[FLG_V] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= ST_IDLE;
      done   <= 1'b0;
      err    <= 1'b0;
      acc_lo <= '0;
      acc_hi <= '0;
      flags  <= '0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            if (is_ill) begin
              // acc and flags deliberately left untouched
              done <= 1'b1;
              err  <= 1'b1;
            end else if (is_mul) begin
              state <= ST_MUL;
            end else begin
              acc_lo <= res;
              acc_hi <= '0;
              flags  <= sc_flags;
              done   <= 1'b1;
            end
          end
        end
        ST_MUL: begin
          // start is ignored here; no queueing
          if (mul_done) begin
            acc_lo <= mul_prod[WIDTH-1:0];
            acc_hi <= mul_prod[2*WIDTH-1:WIDTH];
            flags  <= mul_flags;
            done   <= 1'b1;
            state  <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_alu.sv
// tb/tb_seq_alu.sv - scoreboard testbench for seq_alu (WIDTH=16)

module tb_seq_alu;

  typedef struct packed {
    logic        err;
    logic [15:0] lo;
    logic [15:0] hi;
    logic [3:0]  fl;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        start0 = 1'b0;
  logic [2:0]  op = 3'b000;
  logic        use_acc = 1'b0;
  logic [15:0] a = '0;
  logic [15:0] b = '0;

  logic        busy, done, err;
  logic [15:0] acc_lo, acc_hi;
  logic [3:0]  flags;

  logic        busy0, done0, err0;
  logic [15:0] acc_lo0, acc_hi0;
  logic [3:0]  flags0;

  int passed = 0;
  int total  = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  seq_alu #(.WIDTH(16), .MUL_EN(1'b1)) u_dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .use_acc(use_acc),
    .a(a), .b(b), .busy(busy), .done(done), .err(err),
    .acc_lo(acc_lo), .acc_hi(acc_hi), .flags(flags)
  );

  seq_alu #(.WIDTH(16), .MUL_EN(1'b0)) u_nomul (
    .clk(clk), .rst(rst), .start(start0), .op(op), .use_acc(use_acc),
    .a(a), .b(b), .busy(busy0), .done(done0), .err(err0),
    .acc_lo(acc_lo0), .acc_hi(acc_hi0), .flags(flags0)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Monitor: every done pulse is matched against the oldest expectation.
  always @(negedge clk) begin
    if (!rst && done) begin
      if (sb.size() == 0) begin
        check("unexpected_done", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("sb_err",    {31'd0, err}, {31'd0, e.err});
        check("sb_acc_lo", {16'd0, acc_lo}, {16'd0, e.lo});
        check("sb_acc_hi", {16'd0, acc_hi}, {16'd0, e.hi});
        check("sb_flags",  {28'd0, flags}, {28'd0, e.fl});
      end
    end
  end

  task automatic do_op(input logic [2:0] o, input logic ua, input logic [15:0] aa,
                       input logic [15:0] bb, input logic push, input logic e_err,
                       input logic [15:0] e_lo, input logic [15:0] e_hi, input logic [3:0] e_fl);
    exp_t e;
    e = '{err: e_err, lo: e_lo, hi: e_hi, fl: e_fl};
    if (push) sb.push_back(e);
    start = 1'b1; op = o; use_acc = ua; a = aa; b = bb;
    @(posedge clk); #1;
    start = 1'b0; use_acc = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (n < 40) begin
      @(negedge clk);
      if (!busy) break;
      n++;
    end
    if (n >= 40) check("busy_timeout", 32'd1, 32'd0);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_busy",   {31'd0, busy}, 32'd0);
    check("rst_done",   {31'd0, done}, 32'd0);
    check("rst_err",    {31'd0, err}, 32'd0);
    check("rst_acc_lo", {16'd0, acc_lo}, 32'd0);
    check("rst_acc_hi", {16'd0, acc_hi}, 32'd0);
    check("rst_flags",  {28'd0, flags}, 32'd0);

    // 1. ADD overflow: Z0 N1 C0 V1
    do_op(3'b000, 1'b0, 16'h7FFF, 16'h0001, 1'b1, 1'b0, 16'h8000, 16'h0000, 4'b0101);
    @(negedge clk);
    check("add_done_latency", {31'd0, done}, 32'd1);
    check("add_busy", {31'd0, busy}, 32'd0);
    @(negedge clk);
    check("add_done_pulse", {31'd0, done}, 32'd0);

    // 2. SUB cases, then back-to-back logic ops and ADD carry-out
    do_op(3'b001, 1'b0, 16'h0005, 16'h0005, 1'b1, 1'b0, 16'h0000, 16'h0000, 4'b1010);
    do_op(3'b001, 1'b0, 16'h0000, 16'h0001, 1'b1, 1'b0, 16'hFFFF, 16'h0000, 4'b0100);
    do_op(3'b011, 1'b0, 16'hF0F0, 16'h3C3C, 1'b1, 1'b0, 16'h3030, 16'h0000, 4'b0000);
    do_op(3'b100, 1'b0, 16'h8000, 16'h0001, 1'b1, 1'b0, 16'h8001, 16'h0000, 4'b0100);
    do_op(3'b000, 1'b0, 16'hFFFF, 16'h0001, 1'b1, 1'b0, 16'h0000, 16'h0000, 4'b1010);
    wait_idle();

    // 3. MUL FFFF*FFFF with an ignored ADD injected mid-run
    do_op(3'b101, 1'b0, 16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 16'h0001, 16'hFFFE, 4'b0110);
    cnt = 0;
    while (cnt < 40) begin
      @(negedge clk);
      if (!busy) break;
      cnt++;
      if (cnt == 5) begin start = 1'b1; op = 3'b000; a = 16'h0001; b = 16'h0001; end
      if (cnt == 6) start = 1'b0;
    end
    check("mul_busy_cycles", cnt, 32'd16);

    // 6. illegal op keeps the previous MUL result and flags
    do_op(3'b111, 1'b0, 16'h1234, 16'h5678, 1'b1, 1'b1, 16'h0001, 16'hFFFE, 4'b0110);
    wait_idle();

    // 4. chaining
    do_op(3'b110, 1'b0, 16'h0000, 16'h0003, 1'b1, 1'b0, 16'h0003, 16'h0000, 4'b0000);
    do_op(3'b010, 1'b1, 16'hAAAA, 16'h0001, 1'b1, 1'b0, 16'h0002, 16'h0000, 4'b0000);
    do_op(3'b101, 1'b1, 16'hAAAA, 16'h0004, 1'b1, 1'b0, 16'h0008, 16'h0000, 4'b0000);
    wait_idle();

    // 5. reset aborts a MUL in flight
    do_op(3'b101, 1'b0, 16'h0003, 16'h0005, 1'b0, 1'b0, 16'h0000, 16'h0000, 4'b0000);
    repeat (8) @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("abort_busy",   {31'd0, busy}, 32'd0);
    check("abort_done",   {31'd0, done}, 32'd0);
    check("abort_acc_lo", {16'd0, acc_lo}, 32'd0);
    check("abort_acc_hi", {16'd0, acc_hi}, 32'd0);
    check("abort_flags",  {28'd0, flags}, 32'd0);
    repeat (20) @(negedge clk);
    do_op(3'b000, 1'b0, 16'h0001, 16'h0001, 1'b1, 1'b0, 16'h0002, 16'h0000, 4'b0000);
    wait_idle();

    // MUL opcode on the MUL_EN=0 build is illegal
    start0 = 1'b1; op = 3'b101; a = 16'h0002; b = 16'h0003;
    @(posedge clk); #1 start0 = 1'b0;
    @(negedge clk);
    check("nomul_done",   {31'd0, done0}, 32'd1);
    check("nomul_err",    {31'd0, err0}, 32'd1);
    check("nomul_busy",   {31'd0, busy0}, 32'd0);
    check("nomul_acc_lo", {16'd0, acc_lo0}, 32'd0);
    check("nomul_flags",  {28'd0, flags0}, 32'd0);
    @(negedge clk);
    check("nomul_done_pulse", {31'd0, done0}, 32'd0);

    repeat (4) @(negedge clk);
    check("sb_drained", sb.size(), 32'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
